bit_plane_serializer: RTL and testbench

Transmit-side companion of the bit-serial parallel adder: accepts M words of N bits over a valid/ready word stream, buffers one frame, then emits it one bit plane per clock (plane k = bit k of every word, LSB plane first) on an M-bit bus. It sits directly in front of the adder's `data_bits` input. It tracks the adder's free-running 32-slot frame counter so that plane k appears exactly in slot k. Idle frames are streamed as all-zero planes, so they add nothing to the adder's accumulator.

---
 rtl/bit_plane_pkg.sv | 19 +
 rtl/bit_plane_bank.sv | 28 ++
 rtl/bit_plane_serializer.sv | 124 ++++++++++++
 tb/tb_bit_plane_serializer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/bit_plane_pkg.sv
// Shared constants and types for the bit-plane serializer and its storage banks.
package bit_plane_pkg;

    localparam int M          = 32;
    localparam int N          = 32;
    localparam int SLOT_W     = 5;
    localparam int WORD_IDX_W = $clog2(M);

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL,
        BANK_STREAMING
    } bank_state_e;

    typedef logic [M-1:0] plane_t;
    typedef logic [N-1:0] word_t;

endpackage

// File: rtl/bit_plane_bank.sv
// One frame of storage: written a word at a time, read a bit plane at a time.
module bit_plane_bank
    import bit_plane_pkg::*;
(
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [WORD_IDX_W-1:0] wr_idx_i,
    input  word_t                 wr_word_i,
    input  logic [SLOT_W-1:0]     rd_plane_i,
    output plane_t                rd_data_o
);

    word_t mem_q [M];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_word_i;
        end
    end

    // Plane read is a transpose: column gi of the plane is bit rd_plane_i of word gi.
    generate
        for (genvar gi = 0; gi < M; gi++) begin : g_col
            assign rd_data_o[gi] = mem_q[gi][rd_plane_i];
        end
    endgenerate

endmodule

// File: rtl/bit_plane_serializer.sv
// Word-stream to bit-plane serializer locked to the adder's free-running 32-slot counter.
// Define BIT_PLANE_PINGPONG_EN for two banks (fill one while the other streams); default is one bank.
module bit_plane_serializer
    import bit_plane_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      s_word,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [M-1:0]      data_bits,
    output logic [SLOT_W-1:0] plane_idx,
    output logic              frame_active,
    output logic              frame_start
);

`ifdef BIT_PLANE_PINGPONG_EN
    localparam int NUM_BANKS = 2;
`else
    localparam int NUM_BANKS = 1;
`endif
    localparam logic PINGPONG = (NUM_BANKS == 2);

    logic [SLOT_W-1:0]     slot_q, slot_d;
    logic [WORD_IDX_W-1:0] word_cnt_q, word_cnt_d;
    logic                  wr_sel_q, wr_sel_d;
    logic                  rd_sel_q, rd_sel_d;
    bank_state_e           state_q [NUM_BANKS];
    bank_state_e           state_d [NUM_BANKS];
    plane_t                bank_plane [NUM_BANKS];
    plane_t                data_bits_q, data_bits_d;
    logic                  active_q, active_d;
    logic                  start_q, start_d;

    logic        xfer, last_word, last_slot, free_bank, start_frame, cand_sel;
    bank_state_e wr_state, rd_state, cand_state;
    plane_t      cand_plane;

    generate
        for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            bit_plane_bank u_bank (
                .clk        (clk),
                .wr_en_i    (xfer && (wr_sel_q == 1'(gi))),
                .wr_idx_i   (word_cnt_q),
                .wr_word_i  (s_word),
                .rd_plane_i (slot_d),
                .rd_data_o  (bank_plane[gi])
            );
        end
    endgenerate

    always_comb begin
        wr_state  = (PINGPONG && wr_sel_q) ? state_q[NUM_BANKS-1] : state_q[0];
        rd_state  = (PINGPONG && rd_sel_q) ? state_q[NUM_BANKS-1] : state_q[0];
        s_ready   = (wr_state == BANK_EMPTY || wr_state == BANK_FILLING) && !rst;
        xfer      = s_valid && s_ready;
        last_word = (word_cnt_q == WORD_IDX_W'(M-1));
        last_slot = (slot_q == SLOT_W'(N-1));

        // On the edge into slot 0 the streaming bank retires and the next bank in load order
        // gets its chance to start, so back-to-back frames need no idle slot.
        free_bank  = last_slot && (rd_state == BANK_STREAMING);
        cand_sel   = free_bank ? (rd_sel_q ^ PINGPONG) : rd_sel_q;
        cand_state = (PINGPONG && cand_sel) ? state_q[NUM_BANKS-1] : state_q[0];
        cand_plane = (PINGPONG && cand_sel) ? bank_plane[NUM_BANKS-1] : bank_plane[0];
        start_frame = last_slot && (cand_state == BANK_FULL);

        slot_d     = slot_q + 1'b1;
        word_cnt_d = word_cnt_q;
        if (xfer) begin
            word_cnt_d = last_word ? '0 : word_cnt_q + 1'b1;
        end
        wr_sel_d = wr_sel_q ^ (PINGPONG && xfer && last_word);
        rd_sel_d = cand_sel;

        for (int b = 0; b < NUM_BANKS; b++) begin
            state_d[b] = state_q[b];
            if (xfer && (wr_sel_q == 1'(b))) begin
                state_d[b] = last_word ? BANK_FULL : BANK_FILLING;
            end else if (start_frame && (cand_sel == 1'(b))) begin
                state_d[b] = BANK_STREAMING;
            end else if (free_bank && (rd_sel_q == 1'(b))) begin
                state_d[b] = BANK_EMPTY;
            end
        end

        // Banks are read one slot ahead so the registered plane lands in its own slot.
        active_d    = start_frame || (!last_slot && rd_state == BANK_STREAMING);
        data_bits_d = active_d ? cand_plane : '0;
        start_d     = start_frame;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q      <= '0;
            word_cnt_q  <= '0;
            wr_sel_q    <= 1'b0;
            rd_sel_q    <= 1'b0;
            data_bits_q <= '0;
            active_q    <= 1'b0;
            start_q     <= 1'b0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                state_q[b] <= BANK_EMPTY;
            end
        end else begin
            slot_q      <= slot_d;
            word_cnt_q  <= word_cnt_d;
            wr_sel_q    <= wr_sel_d;
            rd_sel_q    <= rd_sel_d;
            data_bits_q <= data_bits_d;
            active_q    <= active_d;
            start_q     <= start_d;
            for (int b = 0; b < NUM_BANKS; b++) begin
                state_q[b] <= state_d[b];
            end
        end
    end

    assign data_bits    = data_bits_q;
    assign plane_idx    = slot_q;
    assign frame_active = active_q;
    assign frame_start  = start_q;

endmodule

// File: tb/tb_bit_plane_serializer.sv
// Scoreboard bench for bit_plane_serializer: frame-level reference model predicts every slot's output.
module tb_bit_plane_serializer;

`ifdef BIT_PLANE_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_word = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] data_bits;
    logic [4:0]  plane_idx;
    logic        frame_active;
    logic        frame_start;

    bit_plane_serializer dut (
        .clk          (clk),
        .rst          (rst),
        .s_word       (s_word),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .data_bits    (data_bits),
        .plane_idx    (plane_idx),
        .frame_active (frame_active),
        .frame_start  (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint      cyc;
        logic [31:0] plane;
        bit          first;
    } exp_t;

    typedef struct {
        longint from_c;
        longint to_c;
    } occ_t;

    exp_t        exp_q[$];
    occ_t        occ_q[$];
    logic [31:0] cur_words[$];
    longint      cyc = 0;
    int          mslot = 0;
    longint      last_end = 0;
    int          chk_cnt = 0;
    int          pass_cnt = 0;
    int          frame_no = 0;

    // Cycle index and the adder's slot number as the spec defines it.
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        mslot <= rst ? 0 : (mslot + 1) % 32;
    end

    task automatic check(input string name, input bit ok, input logic [63:0] act, input logic [63:0] req);
        chk_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    // A full frame occupies a bank from the cycle after its last word until its slot 31,
    // and streams at the first slot 0 that both follows FULL and follows the previous frame.
    task automatic record_word(input logic [31:0] w);
        longint      d;
        longint      c;
        logic [31:0] p;
        cur_words.push_back(w);
        if (cur_words.size() == 32) begin
            d = (mslot == 31) ? longint'(33) : longint'(32 - mslot);
            c = cyc + d;
            if (c < last_end) c = last_end;
            for (int k = 0; k < 32; k++) begin
                for (int i = 0; i < 32; i++) p[i] = cur_words[i][k];
                exp_q.push_back('{c + longint'(k), p, (k == 0)});
            end
            occ_q.push_back('{cyc + 1, c + 31});
            last_end = c + 32;
            $display("frame %0d: last word cycle %0d slot %0d, plane 0 due cycle %0d",
                     frame_no, cyc, mslot, c);
            frame_no++;
            cur_words.delete();
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap, input int want_slot);
        int gaps;
        int n;
        bit done;
        done = 1'b0;
        gaps = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (gaps) begin
            @(negedge clk);
            s_valid = 1'b0;
        end
        if (want_slot >= 0) begin
            n = 0;
            while (mslot != (want_slot + 31) % 32 && n < 40) begin
                @(negedge clk);
                s_valid = 1'b0;
                #1;
                n++;
            end
        end
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_word  = w;
            #1;
            if (s_ready) begin
                record_word(w);
                done = 1'b1;
                break;
            end
        end
        if (!done) check("s_ready_timeout", 1'b0, 64'(s_ready), 64'd1);
    endtask

    // mode 0: all ones-LSB, 1: word i = i, 2: all 0xFFFFFFFF, 3: random
    task automatic send_frame(input int mode, input int max_gap, input bit late);
        logic [31:0] w;
        for (int i = 0; i < 32; i++) begin
            case (mode)
                0:       w = 32'h0000_0001;
                1:       w = 32'(i);
                2:       w = 32'hFFFF_FFFF;
                default: w = $urandom;
            endcase
            send_word(w, max_gap, (late && i == 31) ? 31 : -1);
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && occ_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check("drain_timeout", 1'b0, 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    // Raises rst immediately; the model discards everything once the reset edge passes.
    task automatic do_reset(input int cycles);
        rst     = 1'b1;
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        occ_q.delete();
        cur_words.delete();
        last_end = 0;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
        $display("reset released at cycle %0d", cyc);
    endtask

    // Monitor: every cycle compares slot, s_ready and the plane against the model.
    exp_t e;
    int   busy;
    bit   exp_rdy;
    always @(negedge clk) begin
        #2;
        check("plane_idx", plane_idx == 5'(mslot), 64'(plane_idx), 64'(mslot));
        while (occ_q.size() > 0 && occ_q[0].to_c < cyc) void'(occ_q.pop_front());
        busy = 0;
        foreach (occ_q[i]) if (occ_q[i].from_c <= cyc && cyc <= occ_q[i].to_c) busy++;
        exp_rdy = !rst && (busy < NB);
        check("s_ready", s_ready === exp_rdy, 64'(s_ready), 64'(exp_rdy));
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            check("plane", data_bits === e.plane && frame_active === 1'b1 && frame_start === e.first,
                  64'({frame_active, frame_start, data_bits}), 64'({1'b1, e.first, e.plane}));
        end else begin
            check("idle", data_bits === 32'd0 && frame_active === 1'b0 && frame_start === 1'b0,
                  64'({frame_active, frame_start, data_bits}), 64'd0);
        end
    end

    initial begin
        bit found;
        do_reset(3);
        send_frame(0, 0, 1'b0);
        drain();
        send_frame(1, 0, 1'b0);
        drain();
        send_frame(2, 3, 1'b0);
        drain();
        send_frame(3, 0, 1'b1);
        drain();
        send_frame(3, 0, 1'b0);
        send_frame(3, 0, 1'b0);
        drain();

        send_frame(3, 0, 1'b0);
        found = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            #1;
            if (frame_active && plane_idx == 5'd10) begin
                found = 1'b1;
                break;
            end
        end
        check("reach_slot10", found, 64'(found), 64'd1);
        do_reset(2);
        repeat (40) @(negedge clk);

        for (int r = 0; r < 3; r++) send_frame(3, 2, 1'b0);
        drain();

        check("scoreboard_empty", exp_q.size() == 0, 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
